// File: rtl/scr1_tapc_dr_unit.sv
// -----------------------------------------------------------------------------
// scr1_tapc_dr_unit
//
// Shared data-register datapath for the debug TAP controller. A single shift
// register serves every DR; its active length follows the current
// instruction. Captures the per-instruction value in DR_CAPTURE, shifts
// LSB-first in DR_SHIFT and commits DAP_CMD / SYS_CTRL contents in DR_UPDATE.
//
// Ports
//   tapc_tck       : TAP clock, all state changes on the rising edge
//   tapc_trst      : asynchronous active-high reset
//   tap_state      : current TAP FSM state (4-bit encoding)
//   tap_instr      : current instruction register value
//   tapc_tdi       : serial data in
//   dbg_id_i       : DBG_ID capture value
//   dap_resp_i     : DAP response captured when DAP_CMD is selected
//   tdo_dr         : serial data out (sr[0])
//   tdo_dr_en      : high while in DR_SHIFT
//   dap_cmd_o      : last DAP command written through DR_UPDATE
//   dap_cmd_vld_o  : one-cycle strobe accompanying a new dap_cmd_o
//   sys_ctrl_o     : system reset request bit
// -----------------------------------------------------------------------------
module scr1_tapc_dr_unit #(
  parameter int DAP_CMD_WIDTH  = 36,
  parameter int DAP_RESP_WIDTH = 33
) (
  input  logic                      tapc_tck,
  input  logic                      tapc_trst,
  input  logic [3:0]                tap_state,
  input  logic [3:0]                tap_instr,
  input  logic                      tapc_tdi,
  input  logic [31:0]               dbg_id_i,
  input  logic [DAP_RESP_WIDTH-1:0] dap_resp_i,
  output logic                      tdo_dr,
  output logic                      tdo_dr_en,
  output logic [DAP_CMD_WIDTH-1:0]  dap_cmd_o,
  output logic                      dap_cmd_vld_o,
  output logic                      sys_ctrl_o
);

  // TAP state encoding
  localparam logic [3:0] ST_RESET      = 4'd0;
  localparam logic [3:0] ST_DR_CAPTURE = 4'd3;
  localparam logic [3:0] ST_DR_SHIFT   = 4'd4;
  localparam logic [3:0] ST_DR_UPDATE  = 4'd8;

  // Instruction encoding
  localparam logic [3:0] INSTR_DBG_ID   = 4'h3;
  localparam logic [3:0] INSTR_BLD_ID   = 4'h4;
  localparam logic [3:0] INSTR_DAP_CMD  = 4'h8;
  localparam logic [3:0] INSTR_SYS_CTRL = 4'h9;
  localparam logic [3:0] INSTR_IDCODE   = 4'hE;

  localparam logic [31:0] TAP_IDCODE  = 32'hDEB01001;
  localparam logic [31:0] SCR1_MIMPID = 32'h22011200;

  localparam int LEN_W = $clog2(DAP_CMD_WIDTH + 1);

  logic [DAP_CMD_WIDTH-1:0] sr_reg, sr_next;
  logic [DAP_CMD_WIDTH-1:0] sr_capture;
  logic [DAP_CMD_WIDTH-1:0] sr_shift;
  logic [DAP_CMD_WIDTH-1:0] dap_cmd_reg, dap_cmd_next;
  logic                     dap_cmd_vld_reg, dap_cmd_vld_next;
  logic                     sys_ctrl_reg, sys_ctrl_next;
  // Set while the previous edge was in DR_UPDATE; limits the strobe to the
  // first DR_UPDATE cycle of each visit.
  logic                     upd_flag_reg, upd_flag_next;
  logic [LEN_W-1:0]         dr_len;
  logic [LEN_W-1:0]         dr_msb;

  // Active DR length; any unknown encoding behaves as BYPASS.
  always_comb begin
    dr_len = LEN_W'(1);
    case (tap_instr)
      INSTR_IDCODE,
      INSTR_BLD_ID,
      INSTR_DBG_ID:   dr_len = LEN_W'(32);
      INSTR_DAP_CMD:  dr_len = LEN_W'(DAP_CMD_WIDTH);
      default:        dr_len = LEN_W'(1);
    endcase
  end

  // dr_len is never zero, so the MSB index never underflows.
  assign dr_msb = dr_len - LEN_W'(1);

  // Capture value, zero-extended to the full register width.
  always_comb begin
    sr_capture = '0;
    case (tap_instr)
      INSTR_IDCODE:   sr_capture[31:0] = TAP_IDCODE;
      INSTR_BLD_ID:   sr_capture[31:0] = SCR1_MIMPID;
      INSTR_DBG_ID:   sr_capture[31:0] = dbg_id_i;
      INSTR_DAP_CMD:  sr_capture[DAP_RESP_WIDTH-1:0] = dap_resp_i;
      INSTR_SYS_CTRL: sr_capture[0] = sys_ctrl_reg;
      default:        sr_capture = '0;
    endcase
  end

  // Shift-right with tdi entering at the active MSB; everything above the
  // active length is cleared so a shorter DR never leaks stale upper bits.
  generate
    for (genvar gi = 0; gi < DAP_CMD_WIDTH; gi++) begin : g_shift
      if (gi < DAP_CMD_WIDTH - 1) begin : g_mid
        assign sr_shift[gi] = (LEN_W'(gi) == dr_msb) ? tapc_tdi :
                              (LEN_W'(gi) <  dr_msb) ? sr_reg[gi+1] : 1'b0;
      end else begin : g_top
        assign sr_shift[gi] = (LEN_W'(gi) == dr_msb) ? tapc_tdi : 1'b0;
      end
    end
  endgenerate

  // Next-state logic. Unlisted states (idle, exits, pause, IR states and
  // unknown values) hold sr and the outputs.
  always_comb begin
    sr_next          = sr_reg;
    dap_cmd_next     = dap_cmd_reg;
    dap_cmd_vld_next = 1'b0;
    sys_ctrl_next    = sys_ctrl_reg;
    upd_flag_next    = 1'b0;
    case (tap_state)
      ST_RESET: begin
        sr_next       = '0;
        sys_ctrl_next = 1'b0;
      end
      ST_DR_CAPTURE: sr_next = sr_capture;
      ST_DR_SHIFT:   sr_next = sr_shift;
      ST_DR_UPDATE: begin
        upd_flag_next = 1'b1;
        if ((tap_instr == INSTR_DAP_CMD) && !upd_flag_reg) begin
          dap_cmd_next     = sr_reg;
          dap_cmd_vld_next = 1'b1;
        end
        if (tap_instr == INSTR_SYS_CTRL) begin
          sys_ctrl_next = sr_reg[0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge tapc_tck or posedge tapc_trst) begin
    if (tapc_trst) begin
      sr_reg          <= '0;
      dap_cmd_reg     <= '0;
      dap_cmd_vld_reg <= 1'b0;
      sys_ctrl_reg    <= 1'b0;
      upd_flag_reg    <= 1'b0;
    end else begin
      sr_reg          <= sr_next;
      dap_cmd_reg     <= dap_cmd_next;
      dap_cmd_vld_reg <= dap_cmd_vld_next;
      sys_ctrl_reg    <= sys_ctrl_next;
      upd_flag_reg    <= upd_flag_next;
    end
  end

  assign tdo_dr        = sr_reg[0];
  assign tdo_dr_en     = (tap_state == ST_DR_SHIFT);
  assign dap_cmd_o     = dap_cmd_reg;
  assign dap_cmd_vld_o = dap_cmd_vld_reg;
  assign sys_ctrl_o    = sys_ctrl_reg;

`ifndef SYNTHESIS
  // An unknown TAP state is held, but it is never legitimate.
  tap_state_known_a : assert property (
    @(posedge tapc_tck) disable iff (tapc_trst) !$isunknown(tap_state)
  );
`endif

endmodule

// File: doc/scr1_tapc_dr_unit.md
SCR1_TAPC_DR_UNIT -- requirements
Module: scr1_tapc_dr_unit

Interface
REQ-001 SHALL have parameter DAP_CMD_WIDTH, default 36, meaning DAP_CMD data register width (4-bit opcode in [35:32] plus 32-bit data in [31:0]).
REQ-002 SHALL have parameter DAP_RESP_WIDTH, default 33, meaning DAP_CMD capture width (1 status bit in [32] plus 32-bit data in [31:0]).
REQ-003 SHALL have ports (name, direction, width, meaning):
- tapc_tck, in, 1: the single clock; all state changes on the rising edge.
- tapc_trst, in, 1: reset, asynchronous and active-high.
- tap_state, in, 4: current TAP state, encoded RESET=0 … DR_SEL_SCAN=2, DR_CAPTURE=3, DR_SHIFT=4, DR_EXIT1=5, DR_PAUSE=6, DR_EXIT2=7, DR_UPDATE=8, IR states 9–15.
- tap_instr, in, 4: current instruction register; DBG_ID=3, BLD_ID=4, SYS_CTRL=9, DAP_CMD=8, IDCODE=E, BYPASS=F.
- tapc_tdi, in, 1: serial data in.
- dbg_id_i, in, 32: DBG_ID capture value.
- dap_resp_i, in, DAP_RESP_WIDTH: DAP response captured for DAP_CMD.
- tdo_dr, out, 1: serial DR data out.
- tdo_dr_en, out, 1: high while tap_state is DR_SHIFT.
- dap_cmd_o, out, DAP_CMD_WIDTH: last updated DAP command.
- dap_cmd_vld_o, out, 1: one-cycle strobe marking a new dap_cmd_o.
- sys_ctrl_o, out, 1: SYS_CTRL register bit (system reset request).

Function
REQ-004 SHALL contain one shift register sr of width DAP_CMD_WIDTH (the maximum DR length) and an active length L selected by tap_instr.
REQ-005 SHALL set L: IDCODE/BLD_ID/DBG_ID=32; DAP_CMD=DAP_CMD_WIDTH; SYS_CTRL=1; BYPASS and every other encoding=1 (treated as BYPASS).
REQ-006 SHALL, on a clock edge with tap_state=DR_CAPTURE, load sr zero-extended with:
- IDCODE: 32'hDEB01001.
- BLD_ID: SCR1_MIMPID.
- DBG_ID: dbg_id_i.
- DAP_CMD: dap_resp_i.
- SYS_CTRL: sys_ctrl_o.
- BYPASS and unrecognised encodings: 0.
REQ-007 SHALL, on a clock edge with tap_state=DR_SHIFT, shift sr right by one, writing tapc_tdi into bit L-1; bits at or above L SHALL be forced to 0.
REQ-008 SHALL hold sr unchanged in DR_EXIT1, DR_PAUSE, DR_EXIT2, DR_UPDATE, IDLE and all IR states.
REQ-009 SHALL drive tdo_dr combinationally as sr[0], and tdo_dr_en = (tap_state==DR_SHIFT).
REQ-010 SHALL, on a clock edge with tap_state=DR_UPDATE and tap_instr=DAP_CMD:
- load dap_cmd_o <= sr[DAP_CMD_WIDTH-1:0];
- assert dap_cmd_vld_o for exactly the next cycle.
REQ-011 SHALL keep dap_cmd_vld_o low in every other cycle, including consecutive cycles in DR_UPDATE; this is one strobe per DR_UPDATE entry, tracked by a one-bit edge flag.
REQ-012 SHALL, on a clock edge with tap_state=DR_UPDATE and tap_instr=SYS_CTRL, load sys_ctrl_o <= sr[0].
REQ-013 SHALL ignore DR_UPDATE for all other instructions; dap_cmd_o and sys_ctrl_o hold.
REQ-014 SHALL, on a clock edge with tap_state=RESET, clear sr, sys_ctrl_o, dap_cmd_vld_o and the edge flag; dap_cmd_o holds.
REQ-015 SHALL give a zero-length shift (CAPTURE directly followed by EXIT1) an update of the captured value unmodified.
REQ-016 SHALL make a tap_instr change between CAPTURE and UPDATE take effect immediately for L and update target; no error is flagged.
REQ-017 SHALL treat tap_state values outside 0–15 or X as hold; an X-assertion in simulation SHALL flag them.

Reset
REQ-018 SHALL, while tapc_trst=1, asynchronously force sr=0, dap_cmd_o=0, dap_cmd_vld_o=0, sys_ctrl_o=0, tdo_dr=0, and clear the edge flag.
REQ-019 SHALL resume normal operation on the first rising tapc_tck after tapc_trst falls; reset mid-shift SHALL discard partial data with no strobe.

Verification
REQ-020 IDCODE: instr=E, CAPTURE, 32 SHIFT cycles with tdi=0 -> tdo_dr sequence LSB-first equals 32'hDEB01001, then 0.
REQ-021 BYPASS: instr=F, CAPTURE then SHIFT with tdi pattern 1,0,1,1 -> tdo_dr = 0,1,0,1 (one-cycle delay).
REQ-022 DAP_CMD: shift 36'h5_1234_5678 LSB-first, then UPDATE for 2 cycles -> dap_cmd_o=36'h512345678; dap_cmd_vld_o high exactly 1 cycle.
REQ-023 SYS_CTRL: shift 1, UPDATE -> sys_ctrl_o=1; capture again -> tdo_dr=1; TAP RESET state -> sys_ctrl_o=0.
REQ-024 Unknown instr=0: CAPTURE/SHIFT with tdi=1 -> behaves as 1-bit bypass; UPDATE -> no dap_cmd_vld_o, sys_ctrl_o unchanged.
REQ-025 Reset mid-DAP_CMD shift after 10 bits: assert tapc_trst -> all outputs 0 immediately; no strobe after release.
